adjacency_store: RTL and testbench

ADJACENCY_STORE -- requirements
Module: adjacency_store

---
 rtl/adjacency_store_if.sv | 35 +++
 rtl/adjacency_store.sv | 158 +++++++++++++++
 tb/tb_adjacency_store.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/adjacency_store_if.sv
// Write/read request and response bundle for adjacency_store.
// master drives requests, slave (the store) returns ready and responses.
interface adjacency_store_if #(
  parameter int READ_PORTS  = 2,
  parameter int INDEX_WIDTH = 3,
  parameter int VALUE_WIDTH = 16
);
  logic                              wr_valid;
  logic [INDEX_WIDTH-1:0]            wr_from;
  logic [INDEX_WIDTH-1:0]            wr_to;
  logic [VALUE_WIDTH-1:0]            wr_data;
  logic                              wr_ready;
  logic                              wr_err;
  logic [READ_PORTS-1:0]             rd_valid;
  logic [READ_PORTS*INDEX_WIDTH-1:0] rd_from;
  logic [READ_PORTS*INDEX_WIDTH-1:0] rd_to;
  logic                              rd_ready;
  logic [READ_PORTS-1:0]             rd_resp_valid;
  logic [READ_PORTS*VALUE_WIDTH-1:0] rd_data;
  logic [READ_PORTS-1:0]             rd_err;

  modport master (
    output wr_valid, wr_from, wr_to, wr_data,
    output rd_valid, rd_from, rd_to,
    input  wr_ready, wr_err,
    input  rd_ready, rd_resp_valid, rd_data, rd_err
  );

  modport slave (
    input  wr_valid, wr_from, wr_to, wr_data,
    input  rd_valid, rd_from, rd_to,
    output wr_ready, wr_err,
    output rd_ready, rd_resp_valid, rd_data, rd_err
  );
endinterface

// File: rtl/adjacency_store.sv
// Weighted adjacency matrix with row-sweep init/clear,
// one write port and READ_PORTS registered read ports.
module adjacency_store #(
  parameter int MAX_NODES   = 8,
  parameter int INDEX_WIDTH = 3,
  parameter int VALUE_WIDTH = 16,
  parameter int READ_PORTS  = 2,
  parameter int SYMMETRIC   = 0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear_req,
  output logic busy,
  adjacency_store_if.slave bus
);

  localparam int CW = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
  localparam int IW = INDEX_WIDTH;
  localparam int VW = VALUE_WIDTH;
  localparam int RP = READ_PORTS;
  localparam logic [VW-1:0] INF = '1;
  localparam logic [IW:0] N_L = (IW+1)'(MAX_NODES);
  localparam logic [CW-1:0] LAST_ROW = CW'(MAX_NODES - 1);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    CLEAR
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  row_q, row_d;
  logic           sweep;
  logic           ready;

  logic [VW-1:0]  mat [MAX_NODES][MAX_NODES];

  function automatic logic in_range(input logic [IW-1:0] i);
    return {1'b0, i} < N_L;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    unique case (state_q)
      INIT, CLEAR: begin
        if (row_q == LAST_ROW) begin
          state_d = IDLE;
          row_d   = '0;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          row_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        row_d   = '0;
      end
    endcase
  end

  assign sweep = (state_q == INIT) || (state_q == CLEAR);
  assign busy  = sweep;
  assign ready = (state_q == IDLE) && !clear_req;
  assign bus.wr_ready = ready;
  assign bus.rd_ready = ready;

  logic          wr_go;
  logic          wr_bad;
  logic [CW-1:0] wf, wt;

  assign wr_go  = bus.wr_valid && ready;
  assign wr_bad = !in_range(bus.wr_from) || !in_range(bus.wr_to)
                  || (bus.wr_from == bus.wr_to);
  assign wf = bus.wr_from[CW-1:0];
  assign wt = bus.wr_to[CW-1:0];

  // Storage has no reset; INIT defines it before any access.
  always_ff @(posedge clock) begin
    if (sweep) begin
      for (int c = 0; c < MAX_NODES; c++) begin
        mat[row_q][CW'(c)] <= (CW'(c) == row_q) ? '0 : INF;
      end
    end else if (wr_go && !wr_bad) begin
      mat[wf][wt] <= bus.wr_data;
      if (SYMMETRIC != 0) begin
        mat[wt][wf] <= bus.wr_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.wr_err <= 1'b0;
    end else begin
      bus.wr_err <= wr_go && wr_bad;
    end
  end

  logic [IW-1:0] rf [RP];
  logic [IW-1:0] rt [RP];
  logic [VW-1:0] rword [RP];
  logic [RP-1:0] rbad;

  always_comb begin
    for (int k = 0; k < RP; k++) begin
      rf[k]    = bus.rd_from[k*IW +: IW];
      rt[k]    = bus.rd_to[k*IW +: IW];
      rbad[k]  = !in_range(rf[k]) || !in_range(rt[k]);
      rword[k] = rbad[k] ? INF
                         : mat[rf[k][CW-1:0]][rt[k][CW-1:0]];
    end
  end

  logic [RP-1:0]    rvalid_q;
  logic [RP-1:0]    rerr_q;
  logic [RP*VW-1:0] rdata_q;

  // Data holds between responses; valid/err pulse for one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rvalid_q <= '0;
      rerr_q   <= '0;
      rdata_q  <= '0;
    end else begin
      for (int k = 0; k < RP; k++) begin
        if (bus.rd_valid[k] && ready) begin
          rvalid_q[k]          <= 1'b1;
          rerr_q[k]            <= rbad[k];
          rdata_q[k*VW +: VW]  <= rword[k];
        end else begin
          rvalid_q[k] <= 1'b0;
          rerr_q[k]   <= 1'b0;
        end
      end
    end
  end

  assign bus.rd_resp_valid = rvalid_q;
  assign bus.rd_err        = rerr_q;
  assign bus.rd_data       = rdata_q;

endmodule

// File: tb/tb_adjacency_store.sv
// Random + directed bench for adjacency_store, directed and
// undirected instances driven in lockstep against a matrix model.
module tb_adjacency_store;

  localparam int N  = 4;
  localparam int IW = 3;
  localparam int VW = 8;
  localparam int RP = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic clear_req = 1'b0;
  logic busy0, busy1;

  adjacency_store_if #(
    .READ_PORTS(RP), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW)
  ) bus ();
  adjacency_store_if #(
    .READ_PORTS(RP), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW)
  ) bs ();

  assign bs.wr_valid = bus.wr_valid;
  assign bs.wr_from  = bus.wr_from;
  assign bs.wr_to    = bus.wr_to;
  assign bs.wr_data  = bus.wr_data;
  assign bs.rd_valid = bus.rd_valid;
  assign bs.rd_from  = bus.rd_from;
  assign bs.rd_to    = bus.rd_to;

  adjacency_store #(
    .MAX_NODES(N), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW),
    .READ_PORTS(RP), .SYMMETRIC(0)
  ) u_dir (
    .clock(clock), .reset_n(reset_n), .clear_req(clear_req),
    .busy(busy0), .bus(bus)
  );

  adjacency_store #(
    .MAX_NODES(N), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW),
    .READ_PORTS(RP), .SYMMETRIC(1)
  ) u_sym (
    .clock(clock), .reset_n(reset_n), .clear_req(clear_req),
    .busy(busy1), .bus(bs)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int busy_left = 0;
  logic [VW-1:0] mdl [2][N][N];
  logic [VW-1:0] last [2][RP];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void minit();
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          mdl[s][r][c] = (r == c) ? 8'h00 : 8'hFF;
  endfunction

  function automatic logic [31:0] out_field(input int s, input int f,
                                            input int k);
    logic [RP*VW-1:0] d;
    case (f)
      0: return 32'(s == 0 ? bus.rd_resp_valid[k] : bs.rd_resp_valid[k]);
      1: return 32'(s == 0 ? bus.rd_err[k] : bs.rd_err[k]);
      2: begin
        d = (s == 0) ? bus.rd_data : bs.rd_data;
        return 32'(d[k*VW +: VW]);
      end
      default: return 32'(s == 0 ? bus.wr_err : bs.wr_err);
    endcase
  endfunction

  task automatic step(input bit wv, input int wf, input int wt,
                      input int wd, input bit [1:0] rv,
                      input int rf0, input int rt0,
                      input int rf1, input int rt1, input bit clr);
    bit busy_e, ready_e, werr_e, wbad;
    bit vld_e [2][RP];
    bit err_e [2][RP];
    int rf [RP];
    int rt [RP];
    rf[0] = rf0; rt[0] = rt0; rf[1] = rf1; rt[1] = rt1;
    bus.wr_valid = wv;
    bus.wr_from  = IW'(wf);
    bus.wr_to    = IW'(wt);
    bus.wr_data  = VW'(wd);
    bus.rd_valid = rv;
    bus.rd_from  = {IW'(rf1), IW'(rf0)};
    bus.rd_to    = {IW'(rt1), IW'(rt0)};
    clear_req    = clr;
    #1;
    busy_e  = (busy_left > 0);
    ready_e = !busy_e && !clr;
    chk("busy_dir", 32'(busy0), 32'(busy_e));
    chk("busy_sym", 32'(busy1), 32'(busy_e));
    chk("wr_ready", 32'(bus.wr_ready), 32'(ready_e));
    chk("rd_ready", 32'(bus.rd_ready), 32'(ready_e));
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < RP; k++) begin
        vld_e[s][k] = rv[k] && ready_e;
        err_e[s][k] = 1'b0;
        if (vld_e[s][k]) begin
          if (rf[k] < N && rt[k] < N) begin
            last[s][k] = mdl[s][rf[k]][rt[k]];
          end else begin
            last[s][k] = 8'hFF;
            err_e[s][k] = 1'b1;
          end
        end
      end
    end
    wbad   = (wf >= N) || (wt >= N) || (wf == wt);
    werr_e = wv && ready_e && wbad;
    if (wv && ready_e && !wbad) begin
      mdl[0][wf][wt] = VW'(wd);
      mdl[1][wf][wt] = VW'(wd);
      mdl[1][wt][wf] = VW'(wd);
    end
    if (busy_left > 0) begin
      busy_left--;
    end else if (clr) begin
      busy_left = N;
      minit();
    end
    @(posedge clock);
    @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("s%0d wr_err", s), out_field(s, 3, 0), 32'(werr_e));
      for (int k = 0; k < RP; k++) begin
        chk($sformatf("s%0d resp_valid%0d", s, k),
            out_field(s, 0, k), 32'(vld_e[s][k]));
        chk($sformatf("s%0d rd_err%0d", s, k),
            out_field(s, 1, k), 32'(err_e[s][k]));
        chk($sformatf("s%0d rd_data%0d", s, k),
            out_field(s, 2, k), 32'(last[s][k]));
      end
    end
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    bus.wr_valid = 0;
    bus.rd_valid = '0;
    clear_req = 0;
    #2 reset_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst busy", 32'(s == 0 ? busy0 : busy1), 32'd1);
      chk("rst wr_err", out_field(s, 3, 0), 32'd0);
      for (int k = 0; k < RP; k++) begin
        chk("rst resp_valid", out_field(s, 0, k), 32'd0);
        chk("rst rd_err", out_field(s, 1, k), 32'd0);
        chk("rst rd_data", out_field(s, 2, k), 32'd0);
        last[s][k] = '0;
      end
    end
    chk("rst wr_ready", 32'(bus.wr_ready), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    busy_left = N;
    minit();
  endtask

  initial begin
    bus.wr_valid = 0;
    bus.wr_from  = '0;
    bus.wr_to    = '0;
    bus.wr_data  = '0;
    bus.rd_valid = '0;
    bus.rd_from  = '0;
    bus.rd_to    = '0;
    @(negedge clock);
    do_reset();
    // INIT window: requests must be refused for exactly N cycles
    for (int i = 0; i < N; i++)
      step(1, 0, 1, 3, 2'b11, 1, 1, 1, 2, 0);
    step(0, 0, 0, 0, 2'b11, 1, 1, 1, 2, 0);
    step(1, 0, 3, 7, 2'b00, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 2'b11, 0, 3, 3, 0, 0);
    step(1, 2, 1, 9, 2'b01, 2, 1, 0, 0, 0);
    step(0, 0, 0, 0, 2'b11, 2, 1, 1, 2, 0);
    step(1, 2, 2, 5, 2'b00, 0, 0, 0, 0, 0);
    step(1, 4, 0, 5, 2'b11, 2, 2, 0, 5, 0);
    step(0, 0, 0, 0, 2'b11, 4, 0, 0, 0, 0);
    step(1, 1, 3, 4, 2'b00, 0, 0, 0, 0, 1);
    for (int i = 0; i < N; i++)
      step(1, 1, 3, 4, 2'b11, 0, 3, 2, 1, 1);
    step(0, 0, 0, 0, 2'b11, 0, 3, 2, 1, 0);
    step(0, 0, 0, 0, 2'b11, 1, 3, 3, 0, 0);
    step(1, 3, 1, 8'h5A, 2'b11, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 2'b11, 3, 1, 1, 3, 0);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1);
    idle_step();
    do_reset();
    for (int i = 0; i < N; i++) idle_step();
    step(0, 0, 0, 0, 2'b11, 3, 1, 1, 3, 0);
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, 5),
           $urandom_range(0, 5), $urandom_range(0, 255),
           2'($urandom_range(0, 3)),
           $urandom_range(0, 4), $urandom_range(0, 4),
           $urandom_range(0, 4), $urandom_range(0, 4),
           $urandom_range(0, 39) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
